// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: two requester ports (index 0 = LSU, 1 = debug/DMA)
// plus the single data-memory port.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic [1:0]             rq_req;
    logic [1:0]             rq_we;
    logic [1:0][ADDR_W-1:0] rq_addr;
    logic [1:0][31:0]       rq_wdata;
    logic [1:0][1:0]        rq_size;
    logic [1:0]             rq_unsigned;
    logic [1:0]             rq_gnt;
    logic [1:0]             rq_rsp_valid;
    logic [1:0][31:0]       rq_rdata;
    logic [1:0]             rq_err;

    logic [ADDR_W-1:0]      mem_addr;
    logic [31:0]            mem_wdata;
    logic [3:0]             mem_write_byte;
    logic                   mem_read_valid;
    logic                   mem_write_valid;
    logic [31:0]            mem_read;

    modport slave (
        input  rq_req, rq_we, rq_addr, rq_wdata, rq_size, rq_unsigned, mem_read,
        output rq_gnt, rq_rsp_valid, rq_rdata, rq_err,
        output mem_addr, mem_wdata, mem_write_byte, mem_read_valid, mem_write_valid
    );

    modport master (
        output rq_req, rq_we, rq_addr, rq_wdata, rq_size, rq_unsigned, mem_read,
        input  rq_gnt, rq_rsp_valid, rq_rdata, rq_err,
        input  mem_addr, mem_wdata, mem_write_byte, mem_read_valid, mem_write_valid
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port data-memory arbiter with one outstanding access, byte-lane steering and load extension.
// Macro ROUND_ROBIN_EN: alternate simultaneous requests; undefined gives fixed priority to port 0.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            r_state, w_next;
    logic              r_we, r_uns, r_owner, r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata, r_rdata;
    logic [1:0]        r_size;
    logic [2:0]        r_cnt;

    logic              w_any, w_sel, w_bad, w_issue;
    logic [1:0]        w_rsize, w_ralo;
    logic [3:0]        w_be;
    logic [31:0]       w_lanes, w_shift, w_ext;
    logic [1:0]        w_gnt, w_rsp;
    logic [1:0][31:0]  w_rdata;

    assign w_any = |bus.rq_req;

`ifdef ROUND_ROBIN_EN
    logic r_ptr;
    // Pointer only breaks ties; a lone requester always wins.
    assign w_sel = (&bus.rq_req) ? r_ptr : bus.rq_req[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          r_ptr <= 1'b0;
        else if (r_state == IDLE && w_any)   r_ptr <= ~w_sel;
    end
`else
    assign w_sel = ~bus.rq_req[0];
`endif

    assign w_rsize = bus.rq_size[w_sel];
    assign w_ralo  = bus.rq_addr[w_sel][1:0];

    always_comb begin
        w_bad = 1'b1;
        unique case (w_rsize)
            2'b00:   w_bad = 1'b0;
            2'b01:   w_bad = w_ralo[0];
            2'b10:   w_bad = |w_ralo;
            default: w_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_any) w_next = w_bad ? RESP : ISSUE;
            ISSUE:   w_next = r_we ? RESP : WAIT;
            WAIT:    if (r_cnt == 3'd1) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_owner <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_size  <= '0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                IDLE: if (w_any) begin
                    r_owner <= w_sel;
                    r_we    <= bus.rq_we[w_sel];
                    r_addr  <= bus.rq_addr[w_sel];
                    r_wdata <= bus.rq_wdata[w_sel];
                    r_size  <= w_rsize;
                    r_uns   <= bus.rq_unsigned[w_sel];
                    r_err   <= w_bad;
                    r_rdata <= '0;
                end
                ISSUE: if (!r_we) r_cnt <= 3'(READ_LAT);
                WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) r_rdata <= w_ext;
                end
                default: ;
            endcase
        end
    end

    // Store lane steering: data replicated so any enabled lane carries the right bytes.
    always_comb begin
        w_be    = 4'b1111;
        w_lanes = r_wdata;
        unique case (r_size)
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_lanes = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_lanes = {2{r_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_shift = bus.mem_read >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_ext = w_shift;
        unique case (r_size)
            2'b00:   w_ext = r_uns ? {24'h0, w_shift[7:0]}  : {{24{w_shift[7]}}, w_shift[7:0]};
            2'b01:   w_ext = r_uns ? {16'h0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
            default: ;
        endcase
    end

    // Memory side is live only in ISSUE, so reset drops every strobe immediately.
    assign w_issue             = (r_state == ISSUE);
    assign bus.mem_addr        = w_issue ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    assign bus.mem_wdata       = (w_issue && r_we) ? w_lanes : '0;
    assign bus.mem_write_byte  = (w_issue && r_we) ? w_be : 4'b0000;
    assign bus.mem_read_valid  = w_issue && !r_we;
    assign bus.mem_write_valid = w_issue && r_we;

    for (genvar p = 0; p < 2; p++) begin : g_port
        assign w_gnt[p]   = (r_state == IDLE) && bus.rq_req[p] && (w_sel == 1'(p));
        assign w_rsp[p]   = (r_state == RESP) && (r_owner == 1'(p));
        assign w_rdata[p] = w_rsp[p] ? r_rdata : '0;
    end

    assign bus.rq_gnt       = w_gnt;
    assign bus.rq_rsp_valid = w_rsp;
    assign bus.rq_rdata     = w_rdata;
    assign bus.rq_err       = w_rsp & {2{r_err}};
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a READ_LAT=1 instance for most scenarios and a
// READ_LAT=3 instance for the long-latency load.
module tb_mem_port_arbiter;
    localparam int RL = 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32)) bus ();
    mem_port_arbiter_if #(.ADDR_W(32)) bus3 ();

    mem_port_arbiter #(.ADDR_W(32), .READ_LAT(RL)) u_dut  (.clk(clk), .reset(reset), .bus(bus));
    mem_port_arbiter #(.ADDR_W(32), .READ_LAT(3))  u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          gcyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    logic [31:0] mem [0:63];
    int          rd_cnt = 0;
    logic [31:0] rd_word;
    int          n_strobe = 0;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_be;
    int          rd3_cnt = 0;
    logic [31:0] rd3_addr = '0;

    always @(posedge clk) cyc++;

    // Memory model: read data is valid only in the cycle READ_LAT after the strobe.
    always @(negedge clk) begin
        if (bus.mem_read_valid && bus.mem_write_valid) begin
            n_fail++;
            $display("FAIL dual_strobe: both read and write strobes high at cycle %0d", cyc);
        end
        if (bus.mem_read_valid) begin
            n_strobe++;
            rd_word      = mem[bus.mem_addr[7:2]];
            rd_cnt       = RL;
            bus.mem_read = 32'hDEAD_BEEF;
        end else if (rd_cnt > 0) begin
            rd_cnt--;
            bus.mem_read = (rd_cnt == 0) ? rd_word : 32'hDEAD_BEEF;
        end else begin
            bus.mem_read = 32'hDEAD_BEEF;
        end
        if (bus.mem_write_valid) begin
            n_strobe++;
            wr_addr = bus.mem_addr;
            wr_be   = bus.mem_write_byte;
            wr_data = bus.mem_wdata;
            for (int b = 0; b < 4; b++)
                if (bus.mem_write_byte[b]) mem[bus.mem_addr[7:2]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
        end
    end

    always @(negedge clk) begin
        if (bus3.mem_read_valid) begin
            rd3_cnt       = 3;
            rd3_addr      = bus3.mem_addr;
            bus3.mem_read = 32'hDEAD_BEEF;
        end else if (rd3_cnt > 0) begin
            rd3_cnt--;
            bus3.mem_read = (rd3_cnt == 0) ? 32'h1234_5678 : 32'hDEAD_BEEF;
        end else begin
            bus3.mem_read = 32'hDEAD_BEEF;
        end
    end

    // Response monitor: pops the scoreboard on every rsp_valid pulse.
    always @(negedge clk) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                if (bus.rq_rsp_valid[p]) begin
                    n_tests++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_rsp: port %0d rdata=%h err=%b, no response expected", p, bus.rq_rdata[p], bus.rq_err[p]);
                    end else begin
                        mon_e = sb.pop_front();
                        if (mon_e.port != p || bus.rq_rdata[p] !== mon_e.rdata || bus.rq_err[p] !== mon_e.err || (cyc - mon_e.gcyc) != mon_e.lat) begin
                            n_fail++;
                            $display("FAIL rsp: got port %0d rdata=%h err=%b lat=%0d, want port %0d rdata=%h err=%b lat=%0d",
                                     p, bus.rq_rdata[p], bus.rq_err[p], cyc - mon_e.gcyc, mon_e.port, mon_e.rdata, mon_e.err, mon_e.lat);
                        end
                    end
                    n_tests++;
                    if (bus.rq_rsp_valid[1-p] !== 1'b0 || bus.rq_rdata[1-p] !== 32'h0 || bus.rq_err[1-p] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL non_owner: port %0d valid=%b rdata=%h err=%b, want all 0", 1-p, bus.rq_rsp_valid[1-p], bus.rq_rdata[1-p], bus.rq_err[1-p]);
                    end
                end
            end
        end
    end

    task automatic wait_drain();
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk); #1;
            k++;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_timeout: %0d responses outstanding, want 0", sb.size());
            sb.delete();
        end
        @(negedge clk); #1;
    endtask

    task automatic access(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] sz, input logic uns,
                          input logic [31:0] erd, input logic eerr, input int elat);
        exp_t e;
        int   k = 0;
        bus.rq_we[p]       = we;
        bus.rq_addr[p]     = addr;
        bus.rq_wdata[p]    = wd;
        bus.rq_size[p]     = sz;
        bus.rq_unsigned[p] = uns;
        bus.rq_req[p]      = 1'b1;
        #1;
        while (!bus.rq_gnt[p] && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        if (!bus.rq_gnt[p]) begin
            n_tests++;
            n_fail++;
            $display("FAIL gnt_timeout: port %0d gnt=0, want 1", p);
        end else begin
            e = '{p, erd, eerr, elat, cyc};
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.rq_req[p] = 1'b0;
        wait_drain();
    endtask

    task automatic test_reset();
        int k = 0;
        #1;
        n_tests++;
        if (bus.rq_gnt !== 2'b00 || bus.rq_rsp_valid !== 2'b00 || bus.rq_err !== 2'b00 || bus.rq_rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rsp: gnt=%b rsp=%b err=%b rdata=%h, want all 0", bus.rq_gnt, bus.rq_rsp_valid, bus.rq_err, bus.rq_rdata);
        end
        n_tests++;
        if (bus.mem_read_valid !== 1'b0 || bus.mem_write_valid !== 1'b0 || bus.mem_addr !== 32'h0 ||
            bus.mem_wdata !== 32'h0 || bus.mem_write_byte !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_mem: rv=%b wv=%b addr=%h wdata=%h be=%b, want all 0",
                     bus.mem_read_valid, bus.mem_write_valid, bus.mem_addr, bus.mem_wdata, bus.mem_write_byte);
        end
        @(negedge clk); reset = 1'b1;
        @(negedge clk); #1;
        // Load from port 0, then pull reset while it sits in WAIT.
        bus.rq_we[0] = 1'b0; bus.rq_addr[0] = 32'h50; bus.rq_size[0] = 2'b10; bus.rq_unsigned[0] = 1'b0;
        bus.rq_req[0] = 1'b1;
        #1;
        while (!bus.rq_gnt[0] && k < 20) begin @(negedge clk); #1; k++; end
        @(posedge clk); #1; bus.rq_req[0] = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (bus.mem_read_valid !== 1'b0 || bus.mem_write_valid !== 1'b0 || bus.rq_rsp_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_abort: rv=%b wv=%b rsp=%b, want 0 0 00", bus.mem_read_valid, bus.mem_write_valid, bus.rq_rsp_valid);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        access(0, 1'b0, 32'h50, 32'h0, 2'b10, 1'b0, mem[20], 1'b0, 2 + RL);
    endtask

    task automatic test_load_half();
        access(0, 1'b0, 32'h12, 32'h0, 2'b01, 1'b0, 32'hFFFF_8001, 1'b0, 2 + RL);
        access(0, 1'b0, 32'h12, 32'h0, 2'b01, 1'b1, 32'h0000_8001, 1'b0, 2 + RL);
        access(1, 1'b0, 32'h10, 32'h0, 2'b01, 1'b0, 32'h0000_0000, 1'b0, 2 + RL);
    endtask

    task automatic test_store();
        access(0, 1'b1, 32'h13, 32'h0000_00AB, 2'b00, 1'b0, 32'h0, 1'b0, 2);
        n_tests++;
        if (wr_addr !== 32'h10 || wr_be !== 4'b1000 || wr_data !== 32'hABAB_ABAB) begin
            n_fail++;
            $display("FAIL store_byte: addr=%h be=%b wdata=%h, want 00000010 1000 abababab", wr_addr, wr_be, wr_data);
        end
        n_tests++;
        if (mem[4] !== 32'hAB01_0000) begin
            n_fail++;
            $display("FAIL store_byte_mem: word=%h, want ab010000", mem[4]);
        end
        access(1, 1'b1, 32'h22, 32'hFFFF_1234, 2'b01, 1'b0, 32'h0, 1'b0, 2);
        n_tests++;
        if (wr_addr !== 32'h20 || wr_be !== 4'b1100 || wr_data[31:16] !== 16'h1234) begin
            n_fail++;
            $display("FAIL store_half: addr=%h be=%b wdata=%h, want 00000020 1100 1234xxxx", wr_addr, wr_be, wr_data);
        end
        access(0, 1'b1, 32'h30, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h0, 1'b0, 2);
        n_tests++;
        if (wr_addr !== 32'h30 || wr_be !== 4'b1111 || wr_data !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL store_word: addr=%h be=%b wdata=%h, want 00000030 1111 cafef00d", wr_addr, wr_be, wr_data);
        end
    endtask

    task automatic test_load_byte();
        access(0, 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 32'hFFFF_FFAB, 1'b0, 2 + RL);
        access(0, 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 32'h0000_00AB, 1'b0, 2 + RL);
        access(1, 1'b0, 32'h12, 32'h0, 2'b00, 1'b0, 32'h0000_0001, 1'b0, 2 + RL);
        access(0, 1'b0, 32'h22, 32'h0, 2'b01, 1'b0, 32'h0000_1234, 1'b0, 2 + RL);
        access(1, 1'b0, 32'h30, 32'h0, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0, 2 + RL);
    endtask

    task automatic test_error();
        int s0 = n_strobe;
        access(1, 1'b0, 32'h21, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 1);
        access(0, 1'b1, 32'h13, 32'h5555_5555, 2'b01, 1'b0, 32'h0, 1'b1, 1);
        access(0, 1'b0, 32'h00, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 1);
        n_tests++;
        if (n_strobe != s0) begin
            n_fail++;
            $display("FAIL err_strobe: %0d memory strobes during errored accesses, want 0", n_strobe - s0);
        end
    endtask

    task automatic test_back_to_back();
        int   order[4];
        int   g = 0;
        int   k = 0;
        int   p;
        int   want;
        exp_t e;
        bus.rq_we       = 2'b00;
        bus.rq_size[0]  = 2'b10; bus.rq_size[1] = 2'b10;
        bus.rq_addr[0]  = 32'h50; bus.rq_addr[1] = 32'h60;
        bus.rq_unsigned = 2'b00;
        bus.rq_req      = 2'b11;
        #1;
        while (g < 4 && k < 100) begin
            if (bus.rq_gnt == 2'b11) begin
                n_tests++;
                n_fail++;
                $display("FAIL dual_gnt: gnt=%b, want one-hot", bus.rq_gnt);
            end
            if (|bus.rq_gnt) begin
                p = bus.rq_gnt[1] ? 1 : 0;
                order[g] = p;
                e = '{p, (p == 1) ? mem[24] : mem[20], 1'b0, 2 + RL, cyc};
                sb.push_back(e);
                g++;
            end
            if (g < 4) begin @(negedge clk); #1; end
            k++;
        end
        @(posedge clk); #1;
        bus.rq_req = 2'b00;
        wait_drain();
        n_tests++;
        if (g != 4) begin
            n_fail++;
            $display("FAIL arb_grants: %0d grants, want 4", g);
        end
        for (int i = 0; i < g; i++) begin
`ifdef ROUND_ROBIN_EN
            want = i % 2;
`else
            want = 0;
`endif
            n_tests++;
            if (order[i] != want) begin
                n_fail++;
                $display("FAIL arb_order[%0d]: port %0d, want port %0d", i, order[i], want);
            end
        end
    endtask

    task automatic test_read_lat3();
        int k = 0;
        int gcyc = -1;
        bus3.rq_we[1] = 1'b0; bus3.rq_addr[1] = 32'h40; bus3.rq_size[1] = 2'b10; bus3.rq_unsigned[1] = 1'b0;
        bus3.rq_req[1] = 1'b1;
        #1;
        while (!bus3.rq_gnt[1] && k < 20) begin @(negedge clk); #1; k++; end
        if (bus3.rq_gnt[1]) gcyc = cyc;
        @(posedge clk); #1;
        bus3.rq_req[1] = 1'b0;
        k = 0;
        while (!bus3.rq_rsp_valid[1] && k < 20) begin @(negedge clk); k++; end
        n_tests++;
        if (!bus3.rq_rsp_valid[1] || gcyc < 0 || (cyc - gcyc) != 5) begin
            n_fail++;
            $display("FAIL lat3_timing: rsp=%b after %0d cycles, want 1 after 5", bus3.rq_rsp_valid[1], cyc - gcyc);
        end
        n_tests++;
        if (bus3.rq_rdata[1] !== 32'h1234_5678 || bus3.rq_err[1] !== 1'b0 || rd3_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL lat3_data: rdata=%h err=%b addr=%h, want 12345678 0 00000040", bus3.rq_rdata[1], bus3.rq_err[1], rd3_addr);
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h5A00_0000 | (i << 8) | i;
        mem[4] = 32'h8001_0000;
        bus.rq_req = '0;  bus.rq_we = '0;  bus.rq_addr = '0;  bus.rq_wdata = '0;
        bus.rq_size = '0; bus.rq_unsigned = '0; bus.mem_read = 32'hDEAD_BEEF;
        bus3.rq_req = '0; bus3.rq_we = '0; bus3.rq_addr = '0; bus3.rq_wdata = '0;
        bus3.rq_size = '0; bus3.rq_unsigned = '0; bus3.mem_read = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        test_reset();
        test_load_half();
        test_store();
        test_load_byte();
        test_error();
        test_back_to_back();
        test_read_lat3();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
